// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter sharing one UART TX among NREQ byte producers.
// Optional stall timeout on a granted but idle requester is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [8*NREQ-1:0] i_req_data,
    input  logic [NREQ-1:0]   i_req_last,
    output logic [NREQ-1:0]   o_req_ready,
    output logic [NREQ-1:0]   o_grant,
    output logic              o_tx_dv,
    output logic [7:0]        o_tx_byte,
    input  logic              i_tx_active,
    input  logic              i_tx_done,
    output logic              o_busy,
    output logic              o_timeout
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, gidx, off, win, ptr_nxt;
    logic [PW:0]     sum;
    logic [NREQ-1:0] rot;
    logic            last_q, fire, take, rel, to_hit;

    // Round-robin search: rotate the valid vector so ptr sits at bit 0, take the lowest set bit, rotate back
    always_comb begin
        rot = NREQ'({i_req_valid, i_req_valid} >> ptr);
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (rot[i]) off = PW'(i);
        sum     = {1'b0, ptr} + {1'b0, off};
        win     = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : PW'(sum);
        ptr_nxt = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        take    = state == IDLE && |i_req_valid;
        fire    = state == ISSUE && i_req_valid[gidx] && !i_tx_active;
        rel     = (state == WAIT && i_tx_done && last_q) || to_hit;
    end

    // Next-state logic; a packet holds the transmitter until its last byte is done or it is revoked
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = take ? ISSUE : IDLE;
            ISSUE:   state_nxt = fire ? WAIT : (to_hit ? IDLE : ISSUE);
            WAIT:    state_nxt = i_tx_done ? (last_q ? IDLE : ISSUE) : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Grant, pointer and transmit byte registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr       <= '0;
            gidx      <= '0;
            o_grant   <= '0;
            o_tx_dv   <= 1'b0;
            o_tx_byte <= 8'h00;
            last_q    <= 1'b0;
        end else begin
            o_tx_dv <= fire;
            if (fire) begin
                o_tx_byte <= i_req_data[{gidx, 3'b000} +: 8];
                last_q    <= i_req_last[gidx];
            end
            if (take) begin
                o_grant <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                gidx    <= win;
            end else if (rel) begin
                o_grant <= '0;
                ptr     <= ptr_nxt;
            end
        end
    end

    assign o_req_ready = fire ? o_grant : '0;
    assign o_busy      = state != IDLE;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] cnt;

    assign to_hit = state == ISSUE && !fire && cnt == 16'(TIMEOUT_CYCLES);

    // Count cycles the granted lane leaves the transmitter idle mid-packet; pulse o_timeout on revoke
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt       <= '0;
            o_timeout <= 1'b0;
        end else begin
            cnt       <= (state != ISSUE || fire || to_hit) ? '0 : cnt + {15'b0, !i_req_valid[gidx]};
            o_timeout <= to_hit;
        end
    end
`else
    assign to_hit    = 1'b0;
    assign o_timeout = 1'b0;
`endif

endmodule
